// File: rtl/odd_parity_pkg.sv
// Shared definitions for the odd-parity serial link (generator and checker sides).
package odd_parity_pkg;

    // Default number of data bits per frame.
    localparam int unsigned DATA_W = 4;

    // Receiver frame-tracking states.
    typedef enum logic [2:0] {
        IDLE,
        DATA,
        PARITY,
        STOP,
        WAIT_IDLE
    } rx_state_t;

    // Parity bit that makes popcount(data) + p odd.
    function automatic logic odd_parity_bit(input logic [DATA_W-1:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/odd_parity_serial_checker_if.sv
// Serial-line and decoded-word signals of the odd-parity checker.
// The slave modport is the checker's view; master is the line/consumer side.
interface odd_parity_serial_checker_if #(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned CNT_W  = 8
);
    logic              bit_en;
    logic              rx;
    logic [DATA_W-1:0] data_out;
    logic              valid;
    logic              par_err;
    logic              frame_err;
    logic [CNT_W-1:0]  err_cnt;
    logic              busy;

    modport master (
        output bit_en,
        output rx,
        input  data_out,
        input  valid,
        input  par_err,
        input  frame_err,
        input  err_cnt,
        input  busy
    );

    modport slave (
        input  bit_en,
        input  rx,
        output data_out,
        output valid,
        output par_err,
        output frame_err,
        output err_cnt,
        output busy
    );
endinterface

// File: rtl/serial_shift_in.sv
// LSB-first shift register: each enabled bit enters at the MSB, so after
// DATA_W shifts the first bit received sits in bit 0.
module serial_shift_in #(
    parameter int unsigned DATA_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clr_i,
    input  logic              en_i,
    input  logic              bit_i,
    output logic [DATA_W-1:0] data_o
);

    logic [DATA_W-1:0] shift_q, shift_d;

    // Next-state: clear has priority over shifting.
    always_comb begin
        shift_d = shift_q;
        if (clr_i) begin
            shift_d = '0;
        end else if (en_i) begin
            shift_d = {bit_i, shift_q[DATA_W-1:1]};
        end
    end

    // Shift register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            shift_q <= '0;
        end else begin
            shift_q <= shift_d;
        end
    end

    assign data_o = shift_q;

endmodule

// File: rtl/odd_parity_serial_checker.sv
// Receive side of the odd-parity link: deserialises start/data/parity/stop
// frames, flags parity and framing errors, and counts bad frames (saturating).
module odd_parity_serial_checker #(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned CNT_W  = 8
) (
    input logic                          clk,
    input logic                          rst,
    odd_parity_serial_checker_if.slave   bus
);
    import odd_parity_pkg::*;

    localparam int unsigned BitCntW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    rx_state_t            state_q, state_d;
    logic [BitCntW-1:0]   bitcnt_q, bitcnt_d;
    logic                 par_q, par_d;
    logic [DATA_W-1:0]    data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 par_err_q, par_err_d;
    logic                 frame_err_q, frame_err_d;
    logic [CNT_W-1:0]     err_cnt_q, err_cnt_d;

    logic                 shift_clr;
    logic                 shift_en;
    logic [DATA_W-1:0]    shift_data;
    logic                 bad_frame;

    serial_shift_in #(
        .DATA_W (DATA_W)
    ) u_shift (
        .clk_i  (clk),
        .rst_i  (rst),
        .clr_i  (shift_clr),
        .en_i   (shift_en),
        .bit_i  (bus.rx),
        .data_o (shift_data)
    );

    // Frame FSM and stop-bit checks; nothing advances without bit_en.
    always_comb begin
        state_d     = state_q;
        bitcnt_d    = bitcnt_q;
        par_d       = par_q;
        data_d      = data_q;
        valid_d     = 1'b0;
        par_err_d   = par_err_q;
        frame_err_d = frame_err_q;
        err_cnt_d   = err_cnt_q;
        shift_clr   = 1'b0;
        shift_en    = 1'b0;
        bad_frame   = 1'b0;

        if (bus.bit_en) begin
            unique case (state_q)
                IDLE: begin
                    // Any low sample is a start bit; no mid-bit recheck.
                    if (!bus.rx) begin
                        state_d   = DATA;
                        bitcnt_d  = '0;
                        shift_clr = 1'b1;
                    end
                end
                DATA: begin
                    shift_en = 1'b1;
                    if (bitcnt_q == BitCntW'(DATA_W - 1)) begin
                        state_d = PARITY;
                    end else begin
                        bitcnt_d = bitcnt_q + BitCntW'(1);
                    end
                end
                PARITY: begin
                    par_d   = bus.rx;
                    state_d = STOP;
                end
                STOP: begin
                    data_d      = shift_data;
                    par_err_d   = (par_q != odd_parity_bit(shift_data));
                    frame_err_d = ~bus.rx;
                    valid_d     = 1'b1;
                    bad_frame   = par_err_d | frame_err_d;
                    // One increment per bad frame, even with both errors.
                    if (bad_frame && (err_cnt_q != '1)) begin
                        err_cnt_d = err_cnt_q + CNT_W'(1);
                    end
                    state_d = bus.rx ? IDLE : WAIT_IDLE;
                end
                WAIT_IDLE: begin
                    // A stuck-low line must return high before a new start.
                    if (bus.rx) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            bitcnt_q    <= '0;
            par_q       <= 1'b0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            par_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            bitcnt_q    <= bitcnt_d;
            par_q       <= par_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            par_err_q   <= par_err_d;
            frame_err_q <= frame_err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign bus.data_out  = data_q;
    // Masked so a pulse registered just before reset never shows while rst is high.
    assign bus.valid     = valid_q & ~rst;
    assign bus.par_err   = par_err_q;
    assign bus.frame_err = frame_err_q;
    assign bus.err_cnt   = err_cnt_q;
    assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_odd_parity_serial_checker.sv
// Scoreboard bench: two checkers (8-bit and 2-bit error counters) share one
// serial line; a frame-level model queues expected results, a monitor pops
// and compares on every valid pulse.
module tb_odd_parity_serial_checker;

    logic clk;
    logic rst;
    logic be;
    logic rxl;

    odd_parity_serial_checker_if #(.DATA_W(4), .CNT_W(8)) bus8 ();
    odd_parity_serial_checker_if #(.DATA_W(4), .CNT_W(2)) bus2 ();

    assign bus8.bit_en = be;
    assign bus8.rx     = rxl;
    assign bus2.bit_en = be;
    assign bus2.rx     = rxl;

    odd_parity_serial_checker #(.DATA_W(4), .CNT_W(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8)
    );

    odd_parity_serial_checker #(.DATA_W(4), .CNT_W(2)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] data;
        logic       pe;
        logic       fe;
        int         c8;
        int         c2;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   m_c8  = 0;
    int   m_c2  = 0;
    int   gap_min = 0;
    int   gap_max = 0;

    function automatic void chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Monitor: compares every valid pulse against the next queued frame.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            if (bus8.valid || bus2.valid) chk("valid_in_reset", 1, 0);
        end else if (bus8.valid || bus2.valid) begin
            chk("valid_agree", int'(bus2.valid), int'(bus8.valid));
            if (q.size() == 0) begin
                chk("unexpected_valid", 1, 0);
            end else begin
                e = q.pop_front();
                chk("data_out",   int'(bus8.data_out),  int'(e.data));
                chk("par_err",    int'(bus8.par_err),   int'(e.pe));
                chk("frame_err",  int'(bus8.frame_err), int'(e.fe));
                chk("err_cnt8",   int'(bus8.err_cnt),   e.c8);
                chk("data_out_2", int'(bus2.data_out),  int'(e.data));
                chk("par_err_2",  int'(bus2.par_err),   int'(e.pe));
                chk("err_cnt2",   int'(bus2.err_cnt),   e.c2);
            end
        end
    end

    // One sampled bit, preceded by a few junk cycles with bit_en low.
    task automatic tick_bit(input logic b);
        int g;
        g = $urandom_range(gap_max, gap_min);
        repeat (g) begin
            @(negedge clk);
            be  = 1'b0;
            rxl = 1'($urandom);
        end
        @(negedge clk);
        be  = 1'b1;
        rxl = b;
    endtask

    task automatic go_quiet();
        @(negedge clk);
        be  = 1'b0;
        rxl = 1'b1;
    endtask

    // Reference model at frame level: odd parity means popcount(data)+p is odd.
    task automatic send_frame(input logic [3:0] d, input logic p, input logic stop,
                              input int n_low);
        exp_t e;
        e.data = d;
        e.pe   = (($countones(d) + int'(p)) % 2) == 0;
        e.fe   = !stop;
        if (e.pe || e.fe) begin
            if (m_c8 < 255) m_c8++;
            if (m_c2 < 3)   m_c2++;
        end
        e.c8 = m_c8;
        e.c2 = m_c2;
        q.push_back(e);
        tick_bit(1'b0);
        for (int i = 0; i < 4; i++) tick_bit(d[i]);
        tick_bit(p);
        tick_bit(stop);
        if (!stop) begin
            repeat (n_low) tick_bit(1'b0);
            go_quiet();
            chk("busy_wait_idle", int'(bus8.busy), 1);
            tick_bit(1'b1);
        end
        go_quiet();
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_data_out"},  int'(bus8.data_out),  0);
        chk({tag, "_valid"},     int'(bus8.valid),     0);
        chk({tag, "_par_err"},   int'(bus8.par_err),   0);
        chk({tag, "_frame_err"}, int'(bus8.frame_err), 0);
        chk({tag, "_err_cnt"},   int'(bus8.err_cnt),   0);
        chk({tag, "_busy"},      int'(bus8.busy),      0);
        chk({tag, "_err_cnt2"},  int'(bus2.err_cnt),   0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] d;
        logic       p;
        logic       stop;

        rst = 1'b1;
        be  = 1'b0;
        rxl = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_cleared("reset");

        // Good frame 0101, p=1.
        send_frame(4'b0101, 1'b1, 1'b1, 0);
        // Parity error 0111 with p=1, then good 0000.
        send_frame(4'b0111, 1'b1, 1'b1, 0);
        send_frame(4'b0000, 1'b1, 1'b1, 0);
        // Framing error with the line held low for three more samples.
        send_frame(4'b1000, 1'b0, 1'b0, 3);
        send_frame(4'b1111, 1'b1, 1'b1, 0);

        // Sparse bit_en: one strobe every third cycle, junk in the gaps.
        gap_min = 2;
        gap_max = 2;
        send_frame(4'b0101, 1'b1, 1'b1, 0);
        gap_min = 0;
        gap_max = 0;

        // Reset after the second data bit abandons the frame.
        tick_bit(1'b0);
        tick_bit(1'b1);
        tick_bit(1'b1);
        @(negedge clk);
        be  = 1'b0;
        rxl = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_c8 = 0;
        m_c2 = 0;
        check_cleared("mid_reset");
        send_frame(4'b0011, 1'b1, 1'b1, 0);

        // Five parity errors: 2-bit counter saturates at 3.
        repeat (5) send_frame(4'b0001, 1'b1, 1'b1, 0);

        // Randomized frames, gaps, errors and back-to-back starts.
        gap_max = 2;
        for (int n = 0; n < 40; n++) begin
            d    = 4'($urandom);
            p    = (($urandom % 4) == 0) ? ~^d : ^d ^ 1'b1;
            p    = (($urandom % 4) == 0) ? ~p : p;
            stop = (($urandom % 5) != 0);
            send_frame(d, p, stop, int'($urandom_range(3, 0)));
            repeat ($urandom_range(2, 0)) tick_bit(1'b1);
        end
        go_quiet();

        repeat (10) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        chk("final_idle", int'(bus8.busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
